keypad_scanner: RTL and testbench

- Drives a physical 4x4 hex matrix keypad and produces the debounced 16-bit key-state vector consumed by the input controller.
- Bit n of the vector is set while CHIP-8 key n is held.
- Scans one row at a time, samples the active-low columns, and debounces over whole frames.
- Flags each new press with a one-cycle event and the lowest newly pressed key code.

---
 rtl/keypad_scanner.sv | 153 +++++++++++++++
 tb/tb_keypad_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with 2-flop column synchronizer and whole-frame debounce.
// Optional ghost-frame rejection is enabled by defining KEYPAD_GHOST_REJECT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] keyboard,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [3:0]      col_s1_q, col_s2_q;
  logic [3:0]      cols;
  logic [2:0][3:0] row_cols_q, row_cols_d;
  logic [15:0]     prev_frame_q, prev_frame_d;
  logic [15:0]     keyboard_q, keyboard_d;
  logic [3:0]      stable_cnt_q, stable_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_event_q, key_event_d;

  logic            sample;
  logic            frame_done;
  logic [3:0][3:0] all_rows;
  logic [15:0]     frame;
  logic [15:0]     new_keys;
  logic            frame_valid;

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1; 4'h1: k = 4'h2; 4'h2: k = 4'h3; 4'h3: k = 4'hC;
      4'h4: k = 4'h4; 4'h5: k = 4'h5; 4'h6: k = 4'h6; 4'h7: k = 4'hD;
      4'h8: k = 4'h7; 4'h9: k = 4'h8; 4'hA: k = 4'h9; 4'hB: k = 4'hE;
      4'hC: k = 4'hA; 4'hD: k = 4'h0; 4'hE: k = 4'hB; default: k = 4'hF;
    endcase
    return k;
  endfunction

  assign cols       = ~col_s2_q;
  assign sample     = (div_cnt_q == DivW'(SCAN_DIV - 1));
  assign frame_done = sample && (row_idx_q == 2'd3);
  // The row-3 sample is live on the completing edge, so it comes straight from cols.
  assign all_rows   = {cols, row_cols_q};
  assign new_keys   = frame & ~keyboard_q;

  always_comb begin
    frame = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (all_rows[r][c]) frame[key_of(2'(r), 2'(c))] = 1'b1;
      end
    end
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  always_comb begin
    frame_valid = 1'b1;
    for (int a = 0; a < 3; a++) begin
      for (int b = a + 1; b < 4; b++) begin
        if ($countones(all_rows[a] & all_rows[b]) >= 2) frame_valid = 1'b0;
      end
    end
  end
`else
  assign frame_valid = 1'b1;
`endif

  always_comb begin
    row_n = 4'b1111;
    row_n[row_idx_q] = 1'b0;
  end

  always_comb begin
    div_cnt_d    = sample ? '0 : div_cnt_q + 1'b1;
    row_idx_d    = sample ? row_idx_q + 2'd1 : row_idx_q;
    row_cols_d   = row_cols_q;
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    keyboard_d   = keyboard_q;
    key_code_d   = key_code_q;
    key_event_d  = 1'b0;

    if (sample) begin
      case (row_idx_q)
        2'd0:    row_cols_d[0] = cols;
        2'd1:    row_cols_d[1] = cols;
        2'd2:    row_cols_d[2] = cols;
        default: ;
      endcase
    end

    if (frame_done) begin
      if (!frame_valid) begin
        stable_cnt_d = '0;
      end else begin
        if (frame == prev_frame_q) begin
          if (stable_cnt_q != 4'd15) stable_cnt_d = stable_cnt_q + 4'd1;
        end else begin
          stable_cnt_d = '0;
          prev_frame_d = frame;
        end
        if ((stable_cnt_d >= 4'(DEBOUNCE_SCANS - 1)) && (frame != keyboard_q)) begin
          keyboard_d = frame;
          if (|new_keys) begin
            key_event_d = 1'b1;
            for (int i = 15; i >= 0; i--) begin
              if (new_keys[i]) key_code_d = 4'(i);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q     <= 4'hF;
      col_s2_q     <= 4'hF;
      div_cnt_q    <= '0;
      row_idx_q    <= '0;
      row_cols_q   <= '0;
      prev_frame_q <= '0;
      stable_cnt_q <= '0;
      keyboard_q   <= '0;
      key_code_q   <= '0;
      key_event_q  <= 1'b0;
    end else begin
      col_s1_q     <= col_n;
      col_s2_q     <= col_s1_q;
      div_cnt_q    <= div_cnt_d;
      row_idx_q    <= row_idx_d;
      row_cols_q   <= row_cols_d;
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      keyboard_q   <= keyboard_d;
      key_code_q   <= key_code_d;
      key_event_q  <= key_event_d;
    end
  end

  assign keyboard  = keyboard_q;
  assign key_event = key_event_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical diode-less matrix model drives col_n, frame-level
// reference model predicts keyboard/key_event/key_code.
module tb_keypad_scanner;

  localparam int unsigned Div = 8;
  localparam int unsigned Deb = 3;
  localparam int unsigned FramePeriod = 4 * Div;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keyboard;
  logic        key_event;
  logic [3:0]  key_code;

  logic [15:0] keys_held;
  int          kmap [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

  int          errors = 0;
  int          checks = 0;
  int          cyc;

  logic [15:0] m_prev, m_kb;
  logic [3:0]  m_cnt, m_code;
  logic        m_ev;

  keypad_scanner #(
    .SCAN_DIV      (Div),
    .DEBOUNCE_SCANS(Deb)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .keyboard (keyboard),
    .key_event(key_event),
    .key_code (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Columns reachable from a driven row through pressed switches (sneak paths included).
  function automatic logic [3:0] reach_cols(input logic [15:0] keys, input int r);
    logic [3:0] rr;
    logic [3:0] cc;
    rr = '0;
    rr[r] = 1'b1;
    cc = '0;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          if (keys[kmap[a*4+b]] && rr[a]) cc[b] = 1'b1;
          if (keys[kmap[a*4+b]] && cc[b]) rr[a] = 1'b1;
        end
      end
    end
    return cc;
  endfunction

  always_comb begin
    logic [3:0] c;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) c = c | reach_cols(keys_held, r);
    end
    col_n = ~c;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_kb   = '0;
    m_cnt  = '0;
    m_code = '0;
    m_ev   = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] keys);
    logic [3:0]  rc [4];
    logic [15:0] f;
    logic [15:0] nw;
    logic        ghost;
    f = '0;
    ghost = 1'b0;
    m_ev = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rc[r] = reach_cols(keys, r);
      for (int c = 0; c < 4; c++) if (rc[r][c]) f[kmap[r*4+c]] = 1'b1;
    end
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if ($countones(rc[a] & rc[b]) >= 2) ghost = 1'b1;
`ifdef KEYPAD_GHOST_REJECT_EN
    if (ghost) begin
      m_cnt = '0;
      return;
    end
`endif
    if (f == m_prev) begin
      if (m_cnt < 15) m_cnt = m_cnt + 1;
    end else begin
      m_cnt = '0;
      m_prev = f;
    end
    if (m_cnt >= Deb - 1 && f != m_kb) begin
      nw = f & ~m_kb;
      m_kb = f;
      if (nw != 0) begin
        m_ev = 1'b1;
        for (int i = 15; i >= 0; i--) if (nw[i]) m_code = 4'(i);
      end
    end
  endtask

  // Starts just after a frame boundary (negedge); ends on the negedge after the completing edge.
  task automatic run_frame(input logic [15:0] keys);
    logic [3:0] er;
    keys_held = keys;
    model_step(keys);
    for (int i = 1; i <= int'(FramePeriod); i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      er = 4'b1111;
      er[(cyc / Div) % 4] = 1'b0;
      chk("row_n", {28'd0, row_n}, {28'd0, er});
      chk("key_event", {31'd0, key_event}, {31'd0, (i == int'(FramePeriod)) ? m_ev : 1'b0});
    end
    chk("keyboard", {16'd0, keyboard}, {16'd0, m_kb});
    chk("key_code", {28'd0, key_code}, {28'd0, m_code});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row_n"}, {28'd0, row_n}, 32'h0000_000E);
    chk({tag, "_keyboard"}, {16'd0, keyboard}, 32'h0);
    chk({tag, "_key_event"}, {31'd0, key_event}, 32'h0);
    chk({tag, "_key_code"}, {28'd0, key_code}, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  initial begin
    logic [15:0] rk;
    rst = 1'b1;
    keys_held = 16'h0020;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_key5");
    release_reset();

    repeat (3) run_frame(16'h0020);
    chk("t1_keyboard", {16'd0, keyboard}, 32'h0020);
    chk("t1_code", {28'd0, key_code}, 32'h5);

    repeat (3) run_frame(16'h0000);
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? 16'h0020 : 16'h0000);
    chk("bounce_keyboard", {16'd0, keyboard}, 32'h0);
    repeat (3) run_frame(16'h0020);
    chk("bounce_hold_keyboard", {16'd0, keyboard}, 32'h0020);

    repeat (3) run_frame(16'h0000);
    repeat (3) run_frame(16'h8000);
    chk("keyF_keyboard", {16'd0, keyboard}, 32'h8000);
    chk("keyF_code", {28'd0, key_code}, 32'hF);
    repeat (3) run_frame(16'h8001);
    chk("keyF0_keyboard", {16'd0, keyboard}, 32'h8001);
    chk("keyF0_code", {28'd0, key_code}, 32'h0);
    repeat (3) run_frame(16'h0000);
    chk("relF0_keyboard", {16'd0, keyboard}, 32'h0);
    chk("relF0_code", {28'd0, key_code}, 32'h0);

    repeat (3) run_frame(16'h1000);
    chk("keyC_keyboard", {16'd0, keyboard}, 32'h1000);
    keys_held = 16'h1000;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("row2_before_rst", {28'd0, row_n}, 32'hB);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    release_reset();
    repeat (2) run_frame(16'h1000);
    chk("post_rst_no_commit", {16'd0, keyboard}, 32'h0);
    run_frame(16'h1000);
    chk("post_rst_commit", {16'd0, keyboard}, 32'h1000);

    repeat (3) run_frame(16'h0000);
    repeat (5) run_frame(16'h0016);
`ifdef KEYPAD_GHOST_REJECT_EN
    chk("ghost_keyboard", {16'd0, keyboard}, 32'h0);
`else
    chk("ghost_keyboard", {16'd0, keyboard}, 32'h0036);
    chk("ghost_code", {28'd0, key_code}, 32'h1);
`endif

    rk = '0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rk = '0;
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) rk[$urandom_range(0, 15)] = 1'b1;
      end
      run_frame(rk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
